// File: rtl/seg_scan_if.sv
// Scanned 7-segment bus plus the rebuilt display image it decodes to.
// master drives the scan and reads the image; slave is the receiver.
interface seg_scan_if;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [5:0]  i_seg_enb;
  logic        i_err_clr;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic [5:0]  o_digit_valid;
  logic        o_frame_valid;
  logic        o_stall;
  logic [2:0]  o_err;

  modport master (
    output i_seg, i_seg_dp, i_seg_enb, i_err_clr,
    input  o_digits, o_dp, o_digit_valid, o_frame_valid, o_stall, o_err
  );

  modport slave (
    input  i_seg, i_seg_dp, i_seg_enb, i_err_clr,
    output o_digits, o_dp, o_digit_valid, o_frame_valid, o_stall, o_err
  );
endinterface

// File: rtl/seg_scan_rx.sv
// Multiplexed 7-segment scan receiver: settles each dwell, decodes to BCD, rebuilds
// the six-digit image, flags bad enables/codes/scan order. Capture lands SETTLE_CYC+1 clocks after a change; no backpressure.
module seg_scan_rx #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50000
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYC);

  logic [6:0]  r_seg,  p_seg;
  logic        r_dp,   p_dp;
  logic [5:0]  r_enb,  p_enb;
  logic        primed;
  logic [7:0]  cnt;
  logic        captured;
  logic [31:0] wd;
  logic [2:0]  last_idx;
  logic        armed;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic [5:0]  dv;
  logic        fv;
  logic [2:0]  err;

  logic        is_active, is_idle, is_invalid, changed, cnt_rst, capture;
  logic        code_bad, order_bad;
  logic [2:0]  idx, exp_prev;
  logic [3:0]  code;
  logic [7:0]  cnt_cur;
  logic [5:0]  dv_base;
  logic [2:0]  err_set;

  // Bit 4 flags a pattern outside the digit/blank set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1110011: decode = 5'h09;
      7'b0000000: decode = 5'h0A;
      default:    decode = 5'h1E;
    endcase
  endfunction

  // primed masks the first post-reset cycle, where r_enb=0 is not a real sample.
  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if (!r_enb[k]) idx = 3'(k);
    end
    is_active  = primed && $onehot(~r_enb);
    is_idle    = (r_enb == 6'h3F);
    is_invalid = primed && !is_active && !is_idle;
    changed    = ({r_seg, r_dp, r_enb} != {p_seg, p_dp, p_enb});
    cnt_rst    = changed || !is_active;
  end

  // cnt_cur counts this cycle as part of the dwell, so a dwell of SETTLE_CYC cycles captures.
  always_comb begin
    if (cnt_rst)             cnt_cur = 8'd0;
    else if (cnt == SETTLE)  cnt_cur = cnt;
    else                     cnt_cur = cnt + 8'd1;
    capture = is_active && !captured && (cnt_cur == SETTLE - 8'd1);
  end

  always_comb begin
    {code_bad, code} = decode(r_seg);
    exp_prev  = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    order_bad = armed && (last_idx != exp_prev);
    err_set   = {capture && order_bad, capture && code_bad, is_invalid};
    dv_base   = (dv == 6'h3F) ? 6'h00 : dv;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg    <= '0;
      r_dp     <= 1'b0;
      r_enb    <= '0;
      p_seg    <= '0;
      p_dp     <= 1'b0;
      p_enb    <= '0;
      primed   <= 1'b0;
      cnt      <= '0;
      captured <= 1'b0;
      wd       <= '0;
      last_idx <= '0;
      armed    <= 1'b0;
      digits   <= '0;
      dp       <= '0;
      dv       <= '0;
      fv       <= 1'b0;
      err      <= '0;
    end else begin
      r_seg  <= bus.i_seg;
      r_dp   <= bus.i_seg_dp;
      r_enb  <= bus.i_seg_enb;
      p_seg  <= r_seg;
      p_dp   <= r_dp;
      p_enb  <= r_enb;
      primed <= 1'b1;
      cnt    <= cnt_cur;

      if (capture)      captured <= 1'b1;
      else if (cnt_rst) captured <= 1'b0;

      if (capture)                  wd <= '0;
      else if (wd != TIMEOUT_CYC)   wd <= wd + 32'd1;

      if (capture) begin
        last_idx <= idx;
        armed    <= 1'b1;
      end

      // A full valid set pulses the frame and clears, but a same-edge capture survives.
      fv <= (dv == 6'h3F);
      dv <= dv_base;
      for (int k = 0; k < 6; k++) begin
        if (capture && idx == 3'(k)) begin
          digits[4*k +: 4] <= code;
          dp[k]            <= r_dp;
          dv[k]            <= 1'b1;
        end
      end

      err <= err_set | (err & {3{~bus.i_err_clr}});
    end
  end

  assign bus.o_digits      = digits;
  assign bus.o_dp          = dp;
  assign bus.o_digit_valid = dv;
  assign bus.o_frame_valid = fv;
  assign bus.o_stall       = (wd >= TIMEOUT_CYC);
  assign bus.o_err         = err;

endmodule
